// File: rtl/rps_match_scorer.sv
// Rock-paper-scissors match scorer. It counts round results and declares a match
// winner on reaching the first-to target or the round limit.
module rps_match_scorer #(
    parameter int MAX_ROUNDS = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       start,
    input  logic       clear,
    input  logic [2:0] target,
    input  logic       round_valid,
    input  logic [1:0] round_winner,
    output logic       round_ready,
    output logic [2:0] p1_score,
    output logic [2:0] p2_score,
    output logic [3:0] rounds,
    output logic [3:0] invalid_cnt,
    output logic       match_done,
    output logic [1:0] match_winner,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PLAY = 2'b01,
        S_DONE = 2'b10
    } state_t;

    localparam logic [3:0] MAX_R = 4'(MAX_ROUNDS);

    state_t     state_q, state_d;
    logic [2:0] p1_q, p1_d, p2_q, p2_d, tgt_q, tgt_d;
    logic [3:0] rounds_q, rounds_d, inv_q, inv_d;
    logic [1:0] win_q, win_d;

    // Candidate counter values for a valid (non-invalid) round in PLAY.
    logic [2:0] p1_nxt, p2_nxt;
    logic [3:0] rounds_nxt;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        p1_d       = p1_q;
        p2_d       = p2_q;
        rounds_d   = rounds_q;
        inv_d      = inv_q;
        win_d      = win_q;
        tgt_d      = tgt_q;
        p1_nxt     = p1_q + 3'(round_winner == 2'b01);
        p2_nxt     = p2_q + 3'(round_winner == 2'b10);
        rounds_nxt = rounds_q + 4'd1;

        if (clear) begin
            // Counters keep their values for inspection. The winner code is only meaningful in DONE.
            state_d = S_IDLE;
            win_d   = 2'b00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d  = S_PLAY;
                        tgt_d    = (target == 3'd0) ? 3'd1 : target;
                        p1_d     = 3'd0;
                        p2_d     = 3'd0;
                        rounds_d = 4'd0;
                        inv_d    = 4'd0;
                        win_d    = 2'b00;
                    end
                end
                S_PLAY: begin
                    if (round_valid) begin
                        if (round_winner == 2'b11) begin
                            if (inv_q != 4'hF) inv_d = inv_q + 4'd1;
                        end else begin
                            // In PLAY, scores stay below target and rounds below MAX_R, so these never wrap.
                            p1_d     = p1_nxt;
                            p2_d     = p2_nxt;
                            rounds_d = rounds_nxt;
                            if (p1_nxt == tgt_q) begin
                                state_d = S_DONE;
                                win_d   = 2'b01;
                            end else if (p2_nxt == tgt_q) begin
                                state_d = S_DONE;
                                win_d   = 2'b10;
                            end else if (rounds_nxt == MAX_R) begin
                                state_d = S_DONE;
                                if (p1_nxt > p2_nxt)      win_d = 2'b01;
                                else if (p2_nxt > p1_nxt) win_d = 2'b10;
                                else                      win_d = 2'b00;
                            end
                        end
                    end
                end
                S_DONE: ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only. Reset is checked before ena so that it always wins.
        if (!rst_n) begin
            state_q  <= S_IDLE;
            p1_q     <= 3'd0;
            p2_q     <= 3'd0;
            rounds_q <= 4'd0;
            inv_q    <= 4'd0;
            win_q    <= 2'b00;
            tgt_q    <= 3'd1;
        end else if (ena) begin
            state_q  <= state_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            rounds_q <= rounds_d;
            inv_q    <= inv_d;
            win_q    <= win_d;
            tgt_q    <= tgt_d;
        end
    end

    assign round_ready  = (state_q == S_PLAY);
    assign match_done   = (state_q == S_DONE);
    assign state        = state_q;
    assign p1_score     = p1_q;
    assign p2_score     = p2_q;
    assign rounds       = rounds_q;
    assign invalid_cnt  = inv_q;
    assign match_winner = win_q;

endmodule

// File: tb/tb_rps_match_scorer.sv
// Bench for rps_match_scorer. It runs directed match scenarios and then randomized
// traffic, comparing the DUT against a score-keeping reference model.
module tb_rps_match_scorer;

    localparam int MAXR = 9;

    logic       clk = 1'b0;
    logic       rst_n, ena, start, clear, round_valid;
    logic [2:0] target;
    logic [1:0] round_winner;
    logic       round_ready, match_done;
    logic [2:0] p1_score, p2_score;
    logic [3:0] rounds, invalid_cnt;
    logic [1:0] match_winner, state;

    int tests = 0;
    int fails = 0;

    // Reference model of the match. Phase: 0 idle, 1 play, 2 done.
    int m_phase, m_p1, m_p2, m_rounds, m_inv, m_win, m_tgt;

    rps_match_scorer #(.MAX_ROUNDS(MAXR)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .clear(clear),
        .target(target), .round_valid(round_valid), .round_winner(round_winner),
        .round_ready(round_ready), .p1_score(p1_score), .p2_score(p2_score),
        .rounds(rounds), .invalid_cnt(invalid_cnt), .match_done(match_done),
        .match_winner(match_winner), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            m_phase = 0; m_p1 = 0; m_p2 = 0; m_rounds = 0; m_inv = 0; m_win = 0; m_tgt = 1;
        end else if (ena) begin
            if (clear) begin
                m_phase = 0;
                m_win   = 0;
            end else if (m_phase == 0 && start) begin
                m_phase = 1;
                m_tgt   = (target == 0) ? 1 : int'(target);
                m_p1 = 0; m_p2 = 0; m_rounds = 0; m_inv = 0; m_win = 0;
            end else if (m_phase == 1 && round_valid) begin
                if (round_winner == 2'b11) begin
                    if (m_inv < 15) m_inv++;
                end else begin
                    if (round_winner == 2'b01) m_p1++;
                    if (round_winner == 2'b10) m_p2++;
                    m_rounds++;
                    if (m_p1 == m_tgt) begin
                        m_phase = 2; m_win = 1;
                    end else if (m_p2 == m_tgt) begin
                        m_phase = 2; m_win = 2;
                    end else if (m_rounds == MAXR) begin
                        m_phase = 2;
                        m_win = (m_p1 > m_p2) ? 1 : (m_p2 > m_p1) ? 2 : 0;
                    end
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".state"},        32'(state),        32'(m_phase));
        check({tag, ".round_ready"},  32'(round_ready),  32'(m_phase == 1));
        check({tag, ".match_done"},   32'(match_done),   32'(m_phase == 2));
        check({tag, ".p1_score"},     32'(p1_score),     32'(m_p1));
        check({tag, ".p2_score"},     32'(p2_score),     32'(m_p2));
        check({tag, ".rounds"},       32'(rounds),       32'(m_rounds));
        check({tag, ".invalid_cnt"},  32'(invalid_cnt),  32'(m_inv));
        check({tag, ".match_winner"}, 32'(match_winner), 32'(m_win));
    endtask

    // One rising edge. The model samples the same inputs the DUT sees, and outputs are checked 1 ns later.
    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic play_round(input logic [1:0] code, input string tag);
        round_valid  = 1'b1;
        round_winner = code;
        tick(tag);
        round_valid  = 1'b0;
    endtask

    task automatic begin_match(input logic [2:0] tgt, input string tag);
        clear = 1'b1;
        tick({tag, ".clr"});
        clear  = 1'b0;
        target = tgt;
        start  = 1'b1;
        tick({tag, ".start"});
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; start = 1'b0; clear = 1'b0;
        target = 3'd0; round_valid = 1'b0; round_winner = 2'b00;
        m_phase = 0; m_p1 = 0; m_p2 = 0; m_rounds = 0; m_inv = 0; m_win = 0; m_tgt = 1;

        // Reset state
        tick("reset");
        check("reset.state_const", 32'(state), 32'd0);
        rst_n = 1'b1;
        tick("idle");

        // First to 2: the rounds go P1, P2, P1. The match ends on the third round.
        begin_match(3'd2, "s1");
        play_round(2'b01, "s1.r1");
        play_round(2'b10, "s1.r2");
        check("s1.not_done_yet", 32'(match_done), 32'd0);
        play_round(2'b01, "s1.r3");
        check("s1.p1", 32'(p1_score), 32'd2);
        check("s1.p2", 32'(p2_score), 32'd1);
        check("s1.done", 32'(match_done), 32'd1);
        check("s1.winner", 32'(match_winner), 32'd1);

        // Nine ties hit the round limit and give a draw. A tenth round is ignored.
        begin_match(3'd3, "s2");
        for (int i = 0; i < 9; i++) play_round(2'b00, "s2.tie");
        check("s2.rounds", 32'(rounds), 32'd9);
        check("s2.winner", 32'(match_winner), 32'd0);
        play_round(2'b00, "s2.extra");
        check("s2.rounds_held", 32'(rounds), 32'd9);
        check("s2.done", 32'(state), 32'd2);

        // A target of 0 counts as 1, so one P2 round ends the match.
        begin_match(3'd0, "s3");
        play_round(2'b10, "s3.r1");
        check("s3.p2", 32'(p2_score), 32'd1);
        check("s3.winner", 32'(match_winner), 32'd2);

        // Invalid codes saturate at 15 without playing a round.
        begin_match(3'd3, "s4");
        for (int i = 0; i < 16; i++) play_round(2'b11, "s4.inv");
        check("s4.inv_sat", 32'(invalid_cnt), 32'd15);
        check("s4.rounds", 32'(rounds), 32'd0);
        check("s4.state", 32'(state), 32'd1);

        // Clear beats round_valid. A new start zeroes the counters.
        begin_match(3'd3, "s5");
        play_round(2'b01, "s5.r1");
        clear = 1'b1; round_valid = 1'b1; round_winner = 2'b01;
        tick("s5.clr_rv");
        clear = 1'b0; round_valid = 1'b0;
        check("s5.idle", 32'(state), 32'd0);
        check("s5.p1_kept", 32'(p1_score), 32'd1);
        start = 1'b1; target = 3'd3;
        tick("s5.restart");
        start = 1'b0;
        check("s5.p1_zero", 32'(p1_score), 32'd0);

        // With ena low, nothing moves. A reset in DONE clears everything.
        ena = 1'b0;
        play_round(2'b01, "s6.frozen");
        check("s6.p1_frozen", 32'(p1_score), 32'd0);
        ena = 1'b1;
        begin_match(3'd1, "s6");
        play_round(2'b01, "s6.win");
        check("s6.done", 32'(state), 32'd2);
        rst_n = 1'b0;
        tick("s6.reset");
        rst_n = 1'b1;
        check("s6.p1_reset", 32'(p1_score), 32'd0);
        check("s6.state_reset", 32'(state), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            rst_n        = ($urandom_range(99) != 0);
            ena          = ($urandom_range(7) != 0);
            clear        = ($urandom_range(24) == 0);
            start        = ($urandom_range(3) == 0);
            target       = 3'($urandom_range(7));
            round_valid  = ($urandom_range(2) != 0);
            round_winner = 2'($urandom_range(3));
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
